wb_serial_tl_bridge: RTL

WB_SERIAL_TL_BRIDGE -- requirements
Module: wb_serial_tl_bridge

---
 rtl/wb_stl_pkg.sv | 30 +++
 rtl/wb_stl_fifo.sv | 60 ++++++
 rtl/wb_serial_tl_bridge.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/wb_stl_pkg.sv
// Shared definitions for the Wishbone to serial-TL bridge: register offsets,
// STATUS/CTRL bit positions and the FIFO count-width helper.
package wb_stl_pkg;

  // Word offsets, decoded from wbs_adr_i[3:2]
  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_RXDATA = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_TX_FULL      = 0;
  localparam int ST_TX_EMPTY     = 1;
  localparam int ST_RX_FULL      = 2;
  localparam int ST_RX_EMPTY     = 3;
  localparam int ST_TX_OVF       = 4;
  localparam int ST_RX_UDF       = 5;
  localparam int ST_TX_COUNT_LSB = 8;
  localparam int ST_RX_COUNT_LSB = 17;
  localparam int ST_COUNT_BITS   = 9;

  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_IRQ_EN = 1;
  localparam int CTRL_FLUSH  = 2;

  // Count must hold the value DEPTH itself, hence one bit beyond the pointer.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_stl_fifo.sv
// Synchronous FIFO with count and flush. No read bypass: a push into an empty
// FIFO becomes visible on rdata the following cycle.
module wb_stl_fifo
  import wb_stl_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          push,
  input  logic                          pop,
  input  logic [WIDTH-1:0]              wdata,
  output logic [WIDTH-1:0]              rdata,
  output logic                          full,
  output logic                          empty,
  output logic [count_width(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign full  = (cnt == CW'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rd_ptr];

  // A full FIFO still takes a push when the same cycle frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/wb_serial_tl_bridge.sv
// Wishbone classic slave exposing a TX and an RX FIFO toward a serial-TL
// link, with sticky error flags and an RX-data-available interrupt.
module wb_serial_tl_bridge
  import wb_stl_pkg::*;
#(
  parameter int W        = 32,
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_ni,
  input  logic          wbs_cyc_i,
  input  logic          wbs_stb_i,
  input  logic          wbs_we_i,
  input  logic [31:0]   wbs_adr_i,
  input  logic [31:0]   wbs_dat_i,
  input  logic [3:0]    wbs_sel_i,
  output logic          wbs_ack_o,
  output logic [31:0]   wbs_dat_o,
  output logic          serial_tl_in_valid_o,
  input  logic          serial_tl_in_ready_i,
  output logic [W-1:0]  serial_tl_in_bits_o,
  input  logic          serial_tl_out_valid_i,
  output logic          serial_tl_out_ready_o,
  input  logic [W-1:0]  serial_tl_out_bits_i,
  output logic          irq_o
);

  localparam int TX_CW = count_width(TX_DEPTH);
  localparam int RX_CW = count_width(RX_DEPTH);

  logic             req;
  logic             wr_req;
  logic             rd_req;
  logic [1:0]       reg_sel;
  logic             wr_tx;
  logic             wr_status;
  logic             wr_ctrl;
  logic             rd_rx;
  logic             flush;

  logic             ctrl_enable;
  logic             ctrl_irq_en;
  logic             tx_ovf;
  logic             rx_udf;

  logic             tx_pop;
  logic             tx_full;
  logic             tx_empty;
  logic [TX_CW-1:0] tx_count;
  logic             rx_push;
  logic [W-1:0]     rx_rdata;
  logic             rx_full;
  logic             rx_empty;
  logic [RX_CW-1:0] rx_count;

  logic [31:0]      status;
  logic [31:0]      rd_data;
  logic             unused_ok;

  // Register actions happen in the request cycle; ack follows one cycle later.
  assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o;
  assign wr_req    = req & wbs_we_i;
  assign rd_req    = req & ~wbs_we_i;
  assign reg_sel   = wbs_adr_i[3:2];
  assign wr_tx     = wr_req && (reg_sel == REG_TXDATA);
  assign wr_status = wr_req && (reg_sel == REG_STATUS);
  assign wr_ctrl   = wr_req && (reg_sel == REG_CTRL);
  assign rd_rx     = rd_req && (reg_sel == REG_RXDATA);
  assign flush     = wr_ctrl & wbs_dat_i[CTRL_FLUSH];

  assign serial_tl_in_valid_o  = ctrl_enable & ~tx_empty;
  assign serial_tl_out_ready_o = ctrl_enable & ~rx_full;
  assign tx_pop                = serial_tl_in_valid_o & serial_tl_in_ready_i;
  assign rx_push               = serial_tl_out_valid_i & serial_tl_out_ready_o;

  assign unused_ok = ^{wbs_sel_i, wbs_adr_i[31:4], wbs_adr_i[1:0], wbs_dat_i};

  wb_stl_fifo #(
    .WIDTH (W),
    .DEPTH (TX_DEPTH)
  ) u_tx_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .flush (flush),
    .push  (wr_tx),
    .pop   (tx_pop),
    .wdata (wbs_dat_i[W-1:0]),
    .rdata (serial_tl_in_bits_o),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  wb_stl_fifo #(
    .WIDTH (W),
    .DEPTH (RX_DEPTH)
  ) u_rx_fifo (
    .clk   (wb_clk_i),
    .rst_n (wb_rst_ni),
    .flush (flush),
    .push  (rx_push),
    .pop   (rd_rx),
    .wdata (serial_tl_out_bits_i),
    .rdata (rx_rdata),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  always_comb begin
    status = '0;
    status[ST_TX_FULL]  = tx_full;
    status[ST_TX_EMPTY] = tx_empty;
    status[ST_RX_FULL]  = rx_full;
    status[ST_RX_EMPTY] = rx_empty;
    status[ST_TX_OVF]   = tx_ovf;
    status[ST_RX_UDF]   = rx_udf;
    status[ST_TX_COUNT_LSB +: TX_CW] = tx_count;
    status[ST_RX_COUNT_LSB +: RX_CW] = rx_count;
  end

  always_comb begin
    rd_data = '0;
    case (reg_sel)
      REG_RXDATA: if (!rx_empty) rd_data[W-1:0] = rx_rdata;
      REG_STATUS: rd_data = status;
      REG_CTRL: begin
        rd_data[CTRL_ENABLE] = ctrl_enable;
        rd_data[CTRL_IRQ_EN] = ctrl_irq_en;
      end
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      wbs_ack_o   <= 1'b0;
      wbs_dat_o   <= '0;
      ctrl_enable <= 1'b0;
      ctrl_irq_en <= 1'b0;
      tx_ovf      <= 1'b0;
      rx_udf      <= 1'b0;
      irq_o       <= 1'b0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd_req ? rd_data : '0;
      if (wr_ctrl) begin
        ctrl_enable <= wbs_dat_i[CTRL_ENABLE];
        ctrl_irq_en <= wbs_dat_i[CTRL_IRQ_EN];
      end
      // A new event in the clearing cycle keeps the flag set.
      tx_ovf <= (tx_ovf & ~wr_status) | (wr_tx & tx_full & ~tx_pop);
      rx_udf <= (rx_udf & ~wr_status) | (rd_rx & rx_empty);
      irq_o  <= ctrl_irq_en & ~rx_empty;
    end
  end

endmodule
